// File: rtl/coin_anim_ctrl.sv
// Coin sprite sequencer: spin frames, 20x20 ROM addressing, collect rise + done pulse.
// Optional COIN_SPIN_PINGPONG_EN: frames bounce 0,1,2,3,2,1,0 instead of wrapping.
module coin_anim_ctrl #(
    parameter int SPRITE_W    = 20,
    parameter int SPRITE_H    = 20,
    parameter int HOLD_FRAMES = 6,
    parameter int RISE_FRAMES = 16,
    parameter int RISE_STEP   = 2
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       spawn,
    input  logic       collect,
    input  logic [9:0] coin_x,
    input  logic [9:0] coin_y,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic [8:0] read_address,
    output logic [1:0] frame_sel,
    output logic       is_coin,
    output logic       coin_active,
    output logic       coin_done
);

    localparam int HW = $clog2(HOLD_FRAMES);
    localparam int RW = $clog2(RISE_FRAMES + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SPIN = 2'd1;
    localparam logic [1:0] RISE = 2'd2;

    logic [1:0]    state;
    logic [1:0]    frame;
    logic [1:0]    frame_adv;
    logic [HW-1:0] hold;
    logic [RW-1:0] rise_cnt;
    logic [9:0]    rise_off;
    logic          frame_clk_d;
    logic          tick;

    assign tick        = frame_clk & ~frame_clk_d;
    assign coin_active = (state == SPIN) || (state == RISE);

`ifdef COIN_SPIN_PINGPONG_EN
    logic dir_up;
    logic dir_adv;

    // Bounce at the ends: 3 turns down, 0 turns up
    always_comb begin
        frame_adv = frame;
        dir_adv   = dir_up;
        if (dir_up) begin
            if (frame == 2'd3) begin
                frame_adv = 2'd2;
                dir_adv   = 1'b0;
            end else begin
                frame_adv = frame + 2'd1;
            end
        end else begin
            if (frame == 2'd0) begin
                frame_adv = 2'd1;
                dir_adv   = 1'b1;
            end else begin
                frame_adv = frame - 2'd1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            dir_up <= 1'b1;
        end else if (state == IDLE && spawn) begin
            dir_up <= 1'b1;
        end else if (tick && state == SPIN && !collect
                     && hold == HW'(HOLD_FRAMES - 1)) begin
            dir_up <= dir_adv;
        end else if (tick && state == RISE && hold == HW'(1)) begin
            dir_up <= dir_adv;
        end
    end
`else
    assign frame_adv = frame + 2'd1;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            frame       <= 2'd0;
            hold        <= '0;
            rise_cnt    <= '0;
            rise_off    <= '0;
            coin_done   <= 1'b0;
            frame_clk_d <= 1'b0;
        end else begin
            frame_clk_d <= frame_clk;
            coin_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (spawn) begin
                        state <= SPIN;
                        frame <= 2'd0;
                        hold  <= '0;
                    end
                end
                SPIN: begin
                    if (collect) begin
                        state    <= RISE;
                        rise_cnt <= '0;
                        rise_off <= '0;
                        hold     <= '0;
                    end else if (tick) begin
                        if (hold == HW'(HOLD_FRAMES - 1)) begin
                            hold  <= '0;
                            frame <= frame_adv;
                        end else begin
                            hold <= hold + HW'(1);
                        end
                    end
                end
                RISE: begin
                    if (tick) begin
                        // Fast spin: advance on every second tick
                        if (hold == HW'(1)) begin
                            hold  <= '0;
                            frame <= frame_adv;
                        end else begin
                            hold <= hold + HW'(1);
                        end
                        if (rise_cnt == RW'(RISE_FRAMES - 1)) begin
                            state     <= IDLE;
                            coin_done <= 1'b1;
                            rise_off  <= '0;
                            rise_cnt  <= '0;
                        end else begin
                            rise_cnt <= rise_cnt + RW'(1);
                            rise_off <= rise_off + 10'(RISE_STEP);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [10:0] yeff;
    logic [10:0] dx;
    logic [10:0] dy;
    logic        in_box;
    logic [8:0]  addr9;

    // Two's-complement 11-bit offsets; sign bit rejects pixels left/above
    assign yeff   = {1'b0, coin_y} - {1'b0, rise_off};
    assign dx     = {1'b0, DrawX} - {1'b0, coin_x};
    assign dy     = {1'b0, DrawY} - yeff;
    assign in_box = !dx[10] && (dx < 11'(SPRITE_W))
                 && !dy[10] && (dy < 11'(SPRITE_H));
    assign addr9  = dy[8:0] * 9'(SPRITE_W) + dx[8:0];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            read_address <= '0;
            frame_sel    <= 2'd0;
            is_coin      <= 1'b0;
        end else begin
            read_address <= in_box ? addr9 : 9'd0;
            frame_sel    <= frame;
            is_coin      <= in_box && coin_active;
        end
    end

endmodule

// File: tb/tb_coin_anim_ctrl.sv
// Scoreboard bench for coin_anim_ctrl: spin cadence, addressing, collect rise, edges.
module tb_coin_anim_ctrl;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic       spawn = 1'b0;
    logic       collect = 1'b0;
    logic [9:0] coin_x = '0;
    logic [9:0] coin_y = '0;
    logic [9:0] DrawX = '0;
    logic [9:0] DrawY = '0;
    logic [8:0] read_address;
    logic [1:0] frame_sel;
    logic       is_coin;
    logic       coin_active;
    logic       coin_done;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int p = 0;

    logic [11:0] exp_q[$];
    string       tag_q[$];

`ifdef COIN_SPIN_PINGPONG_EN
    localparam int NSPIN = 42;
`else
    localparam int NSPIN = 30;
`endif

    coin_anim_ctrl dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
        .spawn(spawn), .collect(collect),
        .coin_x(coin_x), .coin_y(coin_y),
        .DrawX(DrawX), .DrawY(DrawY),
        .read_address(read_address), .frame_sel(frame_sel),
        .is_coin(is_coin), .coin_active(coin_active),
        .coin_done(coin_done)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) if (coin_done === 1'b1) done_cnt++;

    initial begin
        #1ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Frame shown after n advances from a fresh spawn
    function automatic logic [1:0] seqf(input int n);
        int pp[6] = '{0, 1, 2, 3, 2, 1};
`ifdef COIN_SPIN_PINGPONG_EN
        return 2'(pp[n % 6]);
`else
        if (pp[0] != 0) return 2'd0;
        return 2'(n % 4);
`endif
    endfunction

    function automatic logic [11:0] model(input int x, input int y,
                                          input int roff, input bit act,
                                          input logic [1:0] fs);
        int  ddx;
        int  ddy;
        bit  inb;
        logic [8:0] a;
        ddx = x - int'(coin_x);
        ddy = y - (int'(coin_y) - roff);
        inb = (ddx >= 0) && (ddx < 20) && (ddy >= 0) && (ddy < 20);
        a   = inb ? 9'(ddy * 20 + ddx) : 9'd0;
        return {inb && act, fs, a};
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick();
        frame_clk = 1'b1;
        step();
        frame_clk = 1'b0;
        step();
    endtask

    task automatic pix(input int x, input int y, input int roff,
                       input bit act, input string tag);
        DrawX = 10'(x);
        DrawY = 10'(y);
        exp_q.push_back(model(x, y, roff, act, seqf(p)));
        tag_q.push_back(tag);
        step();
        chk(tag_q.pop_front(), 32'({is_coin, frame_sel, read_address}),
            32'(exp_q.pop_front()));
    endtask

    initial begin
        // Reset held with busy inputs
        coin_x = 10'd100;
        coin_y = 10'd50;
        DrawX = 10'd105;
        DrawY = 10'd53;
        spawn = 1'b1;
        collect = 1'b1;
        for (int i = 0; i < 4; i++) begin
            frame_clk = ~frame_clk;
            step();
        end
        chk("rst_addr", 32'(read_address), 0);
        chk("rst_fs", 32'(frame_sel), 0);
        chk("rst_is_coin", 32'(is_coin), 0);
        chk("rst_active", 32'(coin_active), 0);
        chk("rst_done", 32'(coin_done), 0);
        spawn = 1'b0;
        collect = 1'b0;
        frame_clk = 1'b0;
        step();
        Reset_n = 1'b1;
        step();
        step();
        chk("post_rst_active", 32'(coin_active), 0);

        // spawn and collect together: spawn wins
        spawn = 1'b1;
        collect = 1'b1;
        step();
        spawn = 1'b0;
        collect = 1'b0;
        chk("sc_active", 32'(coin_active), 1);
        p = 0;
        for (int k = 1; k <= NSPIN; k++) begin
            tick();
            chk($sformatf("spin_fs_t%0d", k), 32'(frame_sel),
                32'(seqf(k / 6)));
        end
        p = NSPIN / 6;
        chk("spin_active", 32'(coin_active), 1);
        chk("spin_no_done", 32'(done_cnt), 0);

        pix(105, 53, 0, 1, "addr_65");
        pix(120, 53, 0, 1, "addr_right_out");
        pix(99, 53, 0, 1, "addr_left_out");
        pix(119, 69, 0, 1, "addr_399");
        pix(100, 49, 0, 1, "addr_above_out");

        // Collect and rise
        collect = 1'b1;
        step();
        collect = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k == 5) begin
                p = NSPIN / 6 + 2;
                pix(105, 43, 10, 1, "rise5_addr");
            end
        end
        p = NSPIN / 6 + 7;
        chk("rise_active", 32'(coin_active), 1);
        chk("rise_no_done", 32'(done_cnt), 0);
        pix(100, 20, 30, 1, "rise30_top");
        pix(100, 19, 30, 1, "rise30_above");
        tick();
        p = p + 1;
        step();
        step();
        chk("done_once", 32'(done_cnt), 1);
        chk("exit_active", 32'(coin_active), 0);
        pix(105, 53, 0, 0, "idle_not_coin");

        collect = 1'b1;
        step();
        collect = 1'b0;
        step();
        chk("idle_collect_ign", 32'(coin_active), 0);

        // Coin near the top edge while rising
        coin_y = 10'd10;
        spawn = 1'b1;
        step();
        spawn = 1'b0;
        collect = 1'b1;
        step();
        collect = 1'b0;
        for (int k = 1; k <= 10; k++) tick();
        p = 5;
        pix(100, 0, 20, 1, "top_row0");
        pix(100, 9, 20, 1, "top_row9");
        pix(100, 1023, 20, 1, "top_no_wrap");

        // Reset mid-rise: immediate idle, no done pulse
        begin
            int d0;
            d0 = done_cnt;
            #2;
            Reset_n = 1'b0;
            #1;
            chk("midrise_rst_active", 32'(coin_active), 0);
            step();
            Reset_n = 1'b1;
            for (int k = 0; k < 8; k++) tick();
            chk("midrise_no_done", 32'(done_cnt), 32'(d0));
            chk("midrise_idle", 32'(coin_active), 0);
        end

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
